// File: rtl/l2_spi_tx_ctrl_pkg.sv
// Shared definitions for the SPI mode-0 transmit controller.
// State encodings, divider floor, zero-length rule and the byte bit-reverse helper.
package l2_spi_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam int         CLK_DIV_MIN    = 2;
    // A zero length field encodes a full 256-byte frame.
    localparam logic [8:0] LEN_ZERO_BYTES = 9'd256;

    function automatic logic [7:0] bit_rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

endpackage

// File: rtl/l2_spi_tx_ctrl_if.sv
// Byte source and serializer-side signals of the SPI transmit controller.
// master = byte/command source side, slave = the controller.
interface l2_spi_tx_ctrl_if;
    logic       i_start;
    logic [7:0] i_len;
    logic       i_abort;
    logic [7:0] i_byte;
    logic       i_byte_valid;
    logic       o_byte_ready;
    logic       o_cs_n;
    logic       o_sclk;
    logic       o_work_en;
    logic       o_work_pulse;
    logic [7:0] o_byte;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_start, i_len, i_abort, i_byte, i_byte_valid,
        input  o_byte_ready, o_cs_n, o_sclk, o_work_en, o_work_pulse, o_byte, o_busy, o_done
    );

    modport slave (
        input  i_start, i_len, i_abort, i_byte, i_byte_valid,
        output o_byte_ready, o_cs_n, o_sclk, o_work_en, o_work_pulse, o_byte, o_busy, o_done
    );
endinterface

// File: rtl/l2_spi_tx_ctrl_half_tick.sv
// Half-period timer: tick is high on the last cycle of each DIV-cycle window.
// Reload on clr or tick, so the window restarts on every state entry.
module spi_half_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    logic [7:0] cnt_q;

    assign tick = (cnt_q == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 8'(DIV - 1);
        else if (clr || tick)
            cnt_q <= 8'(DIV - 1);
        else
            cnt_q <= cnt_q - 8'd1;
    end
endmodule

// File: rtl/l2_spi_tx_ctrl.sv
// SPI mode-0 transmit controller: frames bytes, drives CS/SCLK and paces an 8-to-1 serializer.
// All outputs registered; byte source is stalled via o_byte_ready, which is only high in LOAD.
module l2_spi_tx_ctrl
    import l2_spi_tx_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    l2_spi_tx_ctrl_if.slave  bus
);
    localparam int DIV = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;

    state_t     state_q, state_d;
    logic [8:0] rem_q, rem_d;
    logic [2:0] bit_q, bit_d;
    logic       phase_q, phase_d;
    logic [7:0] byte_q, byte_d;
    logic       cs_n_q, cs_n_d;
    logic       sclk_q, sclk_d;
    logic       work_en_q, work_en_d;
    logic       pulse_q, pulse_d;
    logic       rdy_q, rdy_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tick, tick_clr, hs;

    spi_half_tick #(.DIV(DIV)) u_half_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rem_q     <= 9'd0;
            bit_q     <= 3'd0;
            phase_q   <= 1'b0;
            byte_q    <= 8'd0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            work_en_q <= 1'b0;
            pulse_q   <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            byte_q    <= byte_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            work_en_q <= work_en_d;
            pulse_q   <= pulse_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        byte_d  = byte_q;
        pulse_d = 1'b0;
        done_d  = 1'b0;
        // rdy_q mirrors "state is LOAD", so this is the accepted-byte strobe.
        hs      = bus.i_byte_valid & rdy_q;

        if (state_q != ST_IDLE && bus.i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        rem_d   = (bus.i_len == 8'd0) ? LEN_ZERO_BYTES : {1'b0, bus.i_len};
                        state_d = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (hs) begin
                        byte_d  = MSB_FIRST ? bit_rev8(bus.i_byte) : bus.i_byte;
                        rem_d   = rem_q - 9'd1;
                        bit_d   = 3'd0;
                        phase_d = 1'b0;
                        pulse_d = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                        end else begin
                            // Falling SCLK edge: next bit starts, or the byte is finished.
                            phase_d = 1'b0;
                            bit_d   = bit_q + 3'd1;
                            if (bit_q == 3'd7)
                                state_d = (rem_q != 9'd0) ? ST_LOAD : ST_HOLD;
                            else
                                pulse_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        tick_clr  = (state_d != state_q);
        cs_n_d    = (state_d == ST_IDLE);
        work_en_d = (state_d != ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        rdy_d     = (state_d == ST_LOAD);
        sclk_d    = (state_d == ST_SHIFT) && phase_d;
    end

    assign bus.o_byte_ready = rdy_q;
    assign bus.o_cs_n       = cs_n_q;
    assign bus.o_sclk       = sclk_q;
    assign bus.o_work_en    = work_en_q;
    assign bus.o_work_pulse = pulse_q;
    assign bus.o_byte       = byte_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;

endmodule

// File: doc/l2_spi_tx_ctrl.md
# l2_spi_tx_ctrl

SPI master transmit controller for mode 0 (CPOL=0, CPHA=0). It accepts a frame length and a stream of bytes, then drives chip-select and SCLK. It also feeds the downstream 8-to-1 serializer through an enable, a one-cycle bit pulse and a held byte. The block sits between the command/byte source and the serializer; the serializer's single-bit output is the MOSI line.

## Interface
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255.
- MSB_FIRST, 0, 1 bit-reverses o_byte so the serializer's LSB-first shifting puts bit 7 on the wire first.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  frame start request; sampled only in IDLE.
- i_len  in  8  bytes in frame, sampled with i_start; 0 means 256.
- i_abort  in  1  terminate the frame immediately.
- i_byte  in  8  next byte to send.
- i_byte_valid  in  1  i_byte is valid.
- o_byte_ready  out  1  controller accepts i_byte this cycle.
- o_cs_n  out  1  chip select, active-low.
- o_sclk  out  1  SPI clock.
- o_work_en  out  1  serializer enable; low clears the serializer bit counter.
- o_work_pulse  out  1  one-clk pulse; the serializer shifts out the next bit.
- o_byte  out  8  byte presented to the serializer, held stable for all 8 pulses.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-clk pulse at normal frame end (not on abort).

## Operation
- States: IDLE, SETUP, LOAD, SHIFT, HOLD.
- Reset values: o_cs_n=1, o_sclk=0, o_work_en=0, o_work_pulse=0, o_byte=0, o_byte_ready=0, o_busy=0, o_done=0, state=IDLE.
- **IDLE**
  - i_start=1 latches the remaining-byte count (0→256, 9-bit) and moves to SETUP.
  - i_start while busy is ignored.
- **SETUP**
  - o_cs_n=0, o_work_en=1, o_busy=1.
  - Lasts CLK_DIV cycles, then moves to LOAD.
- **LOAD**
  - o_byte_ready=1; SCLK held low.
  - On i_byte_valid&o_byte_ready, latches o_byte (bit-reversed if MSB_FIRST), decrements the count, and moves to SHIFT.
  - If i_byte_valid stays low, the controller waits indefinitely; the CS stays low and SCLK idles low.
- **SHIFT**
  - 8 bits; each bit is 2*CLK_DIV cycles: low phase, then high phase.
  - o_work_pulse=1 on the first cycle of each low phase.
  - o_sclk rises at the low→high boundary and falls at the end of the high phase.
  - A 3-bit bit counter increments on each falling edge.
  - After the 8th falling edge: go to LOAD if the count is nonzero, else go to HOLD.
- **HOLD**
  - CS stays low and SCLK stays low for CLK_DIV cycles.
  - Then go to IDLE: o_cs_n=1, o_work_en=0, o_busy=0, o_done=1 for that one cycle.
- **Abort**
  - i_abort=1 in any non-IDLE state: next cycle state=IDLE, o_cs_n=1, o_sclk=0, o_work_en=0, o_work_pulse=0, o_byte_ready=0, o_busy=0, no o_done.
  - A byte handshake in the same cycle as abort is discarded.
  - Abort takes priority over every other event.
- o_work_en stays high across byte boundaries within a frame. The serializer's counter then wraps naturally after 8 pulses.

## Timing
- All outputs are registered.
- i_start at cycle t: SETUP and o_cs_n=0 from t+1.
- The first LOAD cycle is t+1+CLK_DIV.
- Handshake at cycle h: SHIFT from h+1, and o_work_pulse=1 at h+1.
  - Serializer output is valid from h+2.
  - o_sclk rises at h+1+CLK_DIV, at least one full cycle after the data settles.
- A byte occupies 16*CLK_DIV cycles of SHIFT.
- The minimum inter-byte gap is one LOAD cycle with SCLK low.
- Total frame length with i_byte_valid always high: 1 + CLK_DIV + N*(1+16*CLK_DIV) + CLK_DIV cycles from start to the o_done cycle.
- The data change (pulse+1) always happens in the SCLK low phase. The slave samples on the rising edge.

## Structure
- Shared package/header spi_pkg holds:
  - state encodings (3-bit);
  - the CLK_DIV minimum (2);
  - the length-0→256 rule constant.
- One sub-module, spi_half_tick: a CLK_DIV down-counter producing a half-period tick, cleared on state entry. The FSM, the bit counter and the byte counter stay in the top.

## Test plan
- **Single byte, MSB_FIRST=0:** CLK_DIV=2, i_len=1, byte 0xA5 valid always → o_done at cycle 38 after start, 8 pulses, 8 rising SCLK, o_byte=0xA5 throughout SHIFT.
- **Two bytes, MSB_FIRST=1:** CLK_DIV=4, i_len=2, bytes 0x01,0x80 → o_byte=0x80 then 0x01, 16 rising edges, CS low continuously, work_en never drops between bytes.
- **Source stall:** i_len=2, second byte's valid delayed 20 cycles → LOAD holds 20 cycles with SCLK=0, CS=0, no extra pulses; frame completes with o_done.
- **Abort mid-byte:** i_abort at 3rd bit → next cycle CS=1, SCLK=0, work_en=0, o_done never asserted; a new i_start afterwards runs a clean frame.
- **Length zero:** i_len=0 → 256 handshakes, 2048 pulses, then o_done.
- **Start while busy and reset:** i_start mid-frame is ignored; rst_n low mid-SHIFT → all outputs return to reset values asynchronously.
